// File: rtl/coproc_pkg.sv
// Shared types and defaults for the coprocessor arbiter slice.
package coproc_pkg;

    localparam int unsigned DEF_WIDTH  = 18;
    localparam int unsigned DEF_SELW   = 11;
    localparam int unsigned SEL_STATUS = 0;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        SETUP,
        GO,
        SETTLE,
        POLL,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/coproc_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant register.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last_grant;

    // A lone requester wins; on a tie the port not served last wins.
    always_comb begin
        gnt_valid = en & (req0 | req1);
        if (req0 && req1) gnt_port = ~last_grant;
        else              gnt_port = req1;
    end

    // Remember which port received the most recent grant.
    always_ff @(posedge clk) begin
        if (rst)            last_grant <= 1'b1;
        else if (gnt_valid) last_grant <= gnt_port;
    end

endmodule

// File: rtl/coproc_arbiter.sv
// Shares one coprocessor between two requesters: grant, launch, poll busy,
// optionally read a result register, then acknowledge the granted port.
module coproc_arbiter
    import coproc_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SELW    = DEF_SELW,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [SELW-1:0]  sel0,
    input  logic [SELW-1:0]  sel1,
    input  logic [SELW-1:0]  rsel0,
    input  logic [SELW-1:0]  rsel1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] c0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic [SELW-1:0]  cp_sel,
    output logic             cp_go,
    output logic [WIDTH-1:0] cp_a,
    output logic [WIDTH-1:0] cp_b,
    output logic [WIDTH-1:0] cp_c,
    input  logic [WIDTH-1:0] cp_y
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [SELW-1:0] STATUS = SELW'(SEL_STATUS);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              timeout_hit;
    logic [SELW-1:0]   rsel_q, rsel_d;
    logic              port_q, port_d;

    logic [SELW-1:0]   cp_sel_d;
    logic              cp_go_d;
    logic [WIDTH-1:0]  cp_a_d, cp_b_d, cp_c_d, rdata_d;
    logic              ack0_d, ack1_d, err_d, busy_d;

    logic              arb_en, gnt_valid, gnt_port;

    assign arb_en = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req0      (req0),
        .req1      (req1),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rsel_d   = rsel_q;
        port_d   = port_q;
        cp_sel_d = cp_sel;
        cp_go_d  = 1'b0;
        cp_a_d   = cp_a;
        cp_b_d   = cp_b;
        cp_c_d   = cp_c;
        rdata_d  = rdata;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err_d    = 1'b0;
        cnt_inc     = cnt_q + 1'b1;
        timeout_hit = (cnt_inc == CW'(TIMEOUT));

        case (state_q)
            FLUSH: begin
                cp_sel_d = STATUS;
                if (cp_y == '0 || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
                cp_sel_d = STATUS;
                cnt_d    = '0;
                if (gnt_valid) begin
                    state_d = SETUP;
                    port_d  = gnt_port;
                    if (gnt_port) begin
                        cp_sel_d = sel1;
                        rsel_d   = rsel1;
                        cp_a_d   = a1;
                        cp_b_d   = b1;
                        cp_c_d   = c1;
                    end else begin
                        cp_sel_d = sel0;
                        rsel_d   = rsel0;
                        cp_a_d   = a0;
                        cp_b_d   = b0;
                        cp_c_d   = c0;
                    end
                end
            end
            SETUP: begin
                state_d = GO;
                cp_go_d = 1'b1;
            end
            GO: begin
                state_d  = SETTLE;
                cp_sel_d = STATUS;
            end
            SETTLE: begin
                state_d = POLL;
            end
            POLL: begin
                if (cp_y == '0) begin
                    if (rsel_q != '0) begin
                        state_d  = READ;
                        cp_sel_d = rsel_q;
                    end else begin
                        state_d = DONE;
                        rdata_d = '0;
                        ack0_d  = ~port_q;
                        ack1_d  = port_q;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            READ: begin
                state_d  = DONE;
                cp_sel_d = STATUS;
                rdata_d  = cp_y;
                ack0_d   = ~port_q;
                ack1_d   = port_q;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = FLUSH;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, bookkeeping and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            rsel_q  <= '0;
            port_q  <= 1'b0;
            cp_sel  <= '0;
            cp_go   <= 1'b0;
            cp_a    <= '0;
            cp_b    <= '0;
            cp_c    <= '0;
            rdata   <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsel_q  <= rsel_d;
            port_q  <= port_d;
            cp_sel  <= cp_sel_d;
            cp_go   <= cp_go_d;
            cp_a    <= cp_a_d;
            cp_b    <= cp_b_d;
            cp_c    <= cp_c_d;
            rdata   <= rdata_d;
            ack0    <= ack0_d;
            ack1    <= ack1_d;
            err     <= err_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: doc/coproc_arbiter.md
Name: coproc_arbiter

Overview:
- Shares one `coproc` instance between two requesters: port 0 (CPU) and port 1 (auxiliary streamer).
- Per command: grants one requester and drives the coprocessor's sel/a/b/c.
- Pulses `go`, polls busy by reading with sel=0, optionally reads back a result select, then returns the result with a one-cycle ack.
- Sits between the CPU/streamer and `coproc`; replaces software busy-polling.

Parameters:
- WIDTH, 18, data width of a/b/c/y and result.
- SELW, 11, coprocessor select width.
- TIMEOUT, 1023, maximum POLL cycles before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- req0, req1  in  1  request level; held high until matching ack; operands stable while high.
- sel0, sel1  in  SELW  operation select; nonzero required.
- rsel0, rsel1  in  SELW  result select read after completion; 0 = no result.
- a0, b0, c0, a1, b1, c1  in  WIDTH  operands (TOS, NOS, W).
- ack0, ack1  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with ack when timeout aborted the command.
- rdata  out  WIDTH  result, valid during ack.
- busy  out  1  high in any state except IDLE.
- cp_sel  out  SELW  to coproc.sel.
- cp_go  out  1  to coproc.go.
- cp_a, cp_b, cp_c  out  WIDTH  to coproc.a/b/c.
- cp_y  in  WIDTH  from coproc.y; nonzero with sel=0 means busy.

Behaviour:
- All outputs are registered.
- Reset values: state=FLUSH, cp_sel=0, cp_go=0, cp_a/b/c=0, ack0/1=0, err=0, rdata=0, busy=1, last_grant=1, timeout counter=0.
- FLUSH: cp_sel=0.
  - Waits for cp_y==0, because the coprocessor may still be running from before reset.
  - Goes to IDLE the cycle after cp_y==0 is sampled.
  - FLUSH is subject to TIMEOUT; on expiry go to IDLE silently.
- IDLE: cp_sel=0.
  - Single request: grant it.
  - Both requests: grant the port not equal to last_grant, then update last_grant. Port 0 therefore wins the first tie after reset.
  - Grant latches sel/rsel/a/b/c of the winner into cp_* on the same edge, then goes to SETUP.
- SETUP: operands and sel presented for one cycle; cp_go=0. Next state is GO.
- GO: cp_go=1 for exactly one cycle, operands held. Next state is SETTLE.
- SETTLE: cp_sel=0, cp_go=0. Allows coproc to assert busy; cp_y is ignored. Next state is POLL.
- POLL: cp_sel=0.
  - Each cycle: if cp_y==0, go to READ (rsel≠0) or DONE (rsel=0, rdata=0).
  - Otherwise increment the counter; when the counter reaches TIMEOUT, go to DONE with err=1 and rdata=0.
- READ: cp_sel=rsel for one cycle; cp_y is captured into rdata at the end of the cycle. Next state is DONE.
- DONE: ack of the granted port =1 (and err if aborted) for one cycle.
  - cp_sel=0, counter cleared. Next state is IDLE.
  - Requester must drop req the cycle after ack. A req still high in the next IDLE is a new request.
- Latency, request seen in IDLE at cycle 0, busy clear first sampled in POLL at cycle k≥4:
  - ack at k+2 with rsel≠0.
  - ack at k+1 with rsel=0.
  - Minimum is 5 cycles for rsel=0.
- A request arriving during a transaction waits; it is not dropped.
- The ungranted req is not sampled until IDLE.
- rst asserted in any state aborts immediately to reset values. No ack is issued for the aborted command; requesters reissue.
- sel=0 from a requester is illegal. It is processed without assertion checks, and POLL returns immediately.

Decomposition:
- Package `coproc_pkg`:
  - State enum: FLUSH, IDLE, SETUP, GO, SETTLE, POLL, READ, DONE.
  - Localparam SEL_STATUS=0.
  - Shared WIDTH/SELW defaults.
- Natural sub-module: `rr_arb2`, a 2-way round-robin grant with last_grant register. Everything else stays in one FSM.

Test Plan:
- Reset release with coproc model busy for 20 cycles → stays FLUSH, no grant, busy=1; enters IDLE 1 cycle after cp_y==0.
- req0, sel=11'h18, a=18'o777371, b=18'o001116, rsel=0 → cp_sel=18 in SETUP, cp_go one cycle in GO, ack0 at cycle 5 (model not busy), rdata=0.
- req1, sel=11'h78, a=18'o26, rsel=11'h58, model busy 30 cycles then y=18'o123 on sel 58 → ack1 with rdata=18'o123; cp_sel=0 throughout POLL.
- req0 and req1 both high from IDLE, three back-to-back commands each → grant order 0,1,0,1,0,1; no lost requests; exactly one ack per command.
- TIMEOUT=15, model busy forever → ack0 and err pulse together after 15 POLL cycles, rdata=0, return to IDLE.
- rst asserted during POLL → next cycle all outputs at reset values and state FLUSH, no ack; pending req re-served after FLUSH.
